// File: rtl/sub_cfg_loader.sv
// sub_cfg_loader: receives 6-word configuration frames (header + 5 constants)
// over a valid/ready stream. Words are staged in shadow registers and only
// become active, all in the same cycle, once a complete, well-formed frame commits.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   cfg_valid/ready/data/last config word stream (transfer = valid && ready)
//   cons_1..cons_5           active 32-bit constants
//   sel_1..sel_8, rel_opcode active mux selects and relational opcode
//   cfg_done / cfg_err       one-cycle pulse on frame commit / frame reject
//   cfg_loaded               sticky, set at the first commit
module sub_cfg_loader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [31:0] cfg_data,
  input  logic        cfg_last,
  output logic [31:0] cons_1,
  output logic [31:0] cons_2,
  output logic [31:0] cons_3,
  output logic [31:0] cons_4,
  output logic [31:0] cons_5,
  output logic        sel_1,
  output logic [1:0]  sel_2,
  output logic        sel_3,
  output logic [1:0]  sel_4,
  output logic        sel_5,
  output logic [1:0]  sel_6,
  output logic [1:0]  sel_7,
  output logic [1:0]  sel_8,
  output logic [1:0]  rel_opcode,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic        cfg_loaded
);

  localparam int unsigned DW     = 32;
  localparam int unsigned HW     = 15;
  localparam int unsigned CW     = 3;
  localparam int unsigned NCONS  = 5;
  localparam logic [15:0] MAGIC  = 16'hA70C;

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT, DRAIN} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_ready, w_ready_nxt;
  logic            r_done, w_done_nxt;
  logic            r_err, w_err_nxt;
  logic            r_loaded;
  logic            w_hdr_ld, w_cons_ld;
  logic            w_xfer, w_magic_ok;
  logic [HW-1:0]   r_sh_hdr, r_act_hdr;
  logic [DW-1:0]   r_sh_cons  [NCONS];
  logic [DW-1:0]   r_act_cons [NCONS];

  assign w_xfer     = cfg_valid && r_ready;
  assign w_magic_ok = (cfg_data[31:16] == MAGIC);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, shadow-load strobes and next values of the registered pulses
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_hdr_ld    = 1'b0;
    w_cons_ld   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          if (!w_magic_ok) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = cfg_last ? IDLE : DRAIN;
          end else if (cfg_last) begin
            w_err_nxt   = 1'b1;
          end else begin
            w_hdr_ld    = 1'b1;
            w_cnt_nxt   = CW'(1);
            w_state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        if (w_xfer) begin
          if (r_cnt == CW'(NCONS)) begin
            w_cnt_nxt = '0;
            if (cfg_last) begin
              w_cons_ld   = 1'b1;
              w_done_nxt  = 1'b1;
              w_state_nxt = COMMIT;
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = DRAIN;
            end
          end else if (cfg_last) begin
            w_err_nxt   = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_cons_ld = 1'b1;
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      COMMIT: w_state_nxt = IDLE;
      DRAIN: begin
        if (w_xfer && cfg_last) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    w_ready_nxt = (w_state_nxt != COMMIT);
  end

  // Handshake and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_loaded <= 1'b0;
    end else begin
      r_ready  <= w_ready_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_loaded <= r_loaded | w_done_nxt;
    end
  end

  // Shadow staging; a rejected frame clears whatever it had staged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_hdr <= '0;
      for (int i = 0; i < NCONS; i++) r_sh_cons[i] <= '0;
    end else if (w_err_nxt) begin
      r_sh_hdr <= '0;
      for (int i = 0; i < NCONS; i++) r_sh_cons[i] <= '0;
    end else begin
      if (w_hdr_ld) r_sh_hdr <= cfg_data[HW-1:0];
      for (int i = 0; i < NCONS; i++) begin
        if (w_cons_ld && (r_cnt == CW'(i + 1))) r_sh_cons[i] <= cfg_data;
      end
    end
  end

  // Active copy, updated only from COMMIT so all fields change together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_hdr <= '0;
      for (int i = 0; i < NCONS; i++) r_act_cons[i] <= '0;
    end else if (r_state == COMMIT) begin
      r_act_hdr <= r_sh_hdr;
      for (int i = 0; i < NCONS; i++) r_act_cons[i] <= r_sh_cons[i];
    end
  end

  assign cfg_ready  = r_ready;
  assign cfg_done   = r_done;
  assign cfg_err    = r_err;
  assign cfg_loaded = r_loaded;
  assign cons_1     = r_act_cons[0];
  assign cons_2     = r_act_cons[1];
  assign cons_3     = r_act_cons[2];
  assign cons_4     = r_act_cons[3];
  assign cons_5     = r_act_cons[4];
  assign sel_1      = r_act_hdr[14];
  assign sel_2      = r_act_hdr[13:12];
  assign sel_3      = r_act_hdr[11];
  assign sel_4      = r_act_hdr[10:9];
  assign sel_5      = r_act_hdr[8];
  assign sel_6      = r_act_hdr[7:6];
  assign sel_7      = r_act_hdr[5:4];
  assign sel_8      = r_act_hdr[3:2];
  assign rel_opcode = r_act_hdr[1:0];

endmodule

// File: tb/tb_sub_cfg_loader.sv
// tb_sub_cfg_loader: table-driven cycle vectors for the frame protocol and
// error paths, plus hand sequences for reset and randomly gapped frames.
module tb_sub_cfg_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_data;
  logic        cfg_last;
  logic [31:0] cons_1, cons_2, cons_3, cons_4, cons_5;
  logic        sel_1, sel_3, sel_5;
  logic [1:0]  sel_2, sel_4, sel_6, sel_7, sel_8, rel_opcode;
  logic        cfg_done, cfg_err, cfg_loaded;
  logic [14:0] w_sel;

  int n_tot  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign w_sel = {sel_1, sel_2, sel_3, sel_4, sel_5, sel_6, sel_7, sel_8, rel_opcode};

  sub_cfg_loader dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .cons_1(cons_1), .cons_2(cons_2), .cons_3(cons_3), .cons_4(cons_4), .cons_5(cons_5),
    .sel_1(sel_1), .sel_2(sel_2), .sel_3(sel_3), .sel_4(sel_4), .sel_5(sel_5),
    .sel_6(sel_6), .sel_7(sel_7), .sel_8(sel_8), .rel_opcode(rel_opcode),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .cfg_loaded(cfg_loaded)
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        l;
    logic        done;
    logic        err;
    logic        rdy;
    logic        ld;
    logic [31:0] c1;
    logic [31:0] c5;
    logic [14:0] sel;
  } vec_t;

  vec_t tbl[$];

  // Expected "active" state while building the table
  logic        e_ld;
  logic [31:0] e_c1, e_c5;
  logic [14:0] e_sel;

  function automatic void add(input logic v, input logic [31:0] d, input logic l,
                              input logic done, input logic err, input logic rdy);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.done = done; r.err = err; r.rdy = rdy;
    r.ld = e_ld; r.c1 = e_c1; r.c5 = e_c5; r.sel = e_sel;
    tbl.push_back(r);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge
  task automatic step(input logic v, input logic [31:0] d, input logic l);
    cfg_valid = v; cfg_data = d; cfg_last = l;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"},  32'(cfg_ready), 32'd0);
    chk({tag, "_done"},   32'(cfg_done), 32'd0);
    chk({tag, "_err"},    32'(cfg_err), 32'd0);
    chk({tag, "_loaded"}, 32'(cfg_loaded), 32'd0);
    chk({tag, "_c1"}, cons_1, 32'd0);
    chk({tag, "_c2"}, cons_2, 32'd0);
    chk({tag, "_c3"}, cons_3, 32'd0);
    chk({tag, "_c4"}, cons_4, 32'd0);
    chk({tag, "_c5"}, cons_5, 32'd0);
    chk({tag, "_sel"}, 32'(w_sel), 32'd0);
  endtask

  initial begin
    logic [31:0] frm [6];
    int gap;

    // ---------------- table construction ----------------
    e_ld = 1'b0; e_c1 = '0; e_c5 = '0; e_sel = '0;
    // Good frame A, back to back; COMMIT cycle offers a junk word that must not transfer
    add(1, 32'hA70C_7FFF, 0, 0, 0, 1);
    add(1, 32'd1, 0, 0, 0, 1);
    add(1, 32'd2, 0, 0, 0, 1);
    add(1, 32'd3, 0, 0, 0, 1);
    add(1, 32'd4, 0, 0, 0, 1);
    e_ld = 1'b1;
    add(1, 32'd5, 1, 1, 0, 0);
    e_c1 = 32'd1; e_c5 = 32'd5; e_sel = 15'h7FFF;
    add(1, 32'h1234_0000, 1, 0, 0, 1);
    // Bad magic, then drain to last
    add(1, 32'h1234_0000, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) add(1, 32'd0, 0, 0, 0, 1);
    add(1, 32'd0, 1, 0, 0, 1);
    // Good frame B with stall cycles
    add(1, 32'hA70C_4A5B, 0, 0, 0, 1);
    add(0, 32'hFFFF_FFFF, 1, 0, 0, 1);
    add(1, 32'hDEAD_BEEF, 0, 0, 0, 1);
    add(1, 32'd2, 0, 0, 0, 1);
    add(0, 32'd0, 1, 0, 0, 1);
    add(1, 32'd3, 0, 0, 0, 1);
    add(1, 32'd4, 0, 0, 0, 1);
    add(1, 32'hFFFF_FFFF, 1, 1, 0, 0);
    e_c1 = 32'hDEAD_BEEF; e_c5 = 32'hFFFF_FFFF; e_sel = 15'h4A5B;
    add(0, 32'd0, 0, 0, 0, 1);
    // Early last on word 3
    add(1, 32'hA70C_7FFF, 0, 0, 0, 1);
    add(1, 32'd9, 0, 0, 0, 1);
    add(1, 32'd9, 1, 0, 1, 1);
    add(0, 32'd0, 0, 0, 0, 1);
    // Missing last on word 6, then two junk words
    add(1, 32'hA70C_7FFF, 0, 0, 0, 1);
    for (int i = 6; i < 10; i++) add(1, 32'(i), 0, 0, 0, 1);
    add(1, 32'hA, 0, 0, 1, 1);
    add(1, 32'hB, 0, 0, 0, 1);
    add(1, 32'hC, 1, 0, 0, 1);
    // Good magic header carrying last
    add(1, 32'hA70C_0000, 1, 0, 1, 1);
    // Good frame C commits from IDLE
    add(1, 32'hA70C_0000, 0, 0, 0, 1);
    for (int i = 1; i < 5; i++) add(1, 32'(i * 256), 0, 0, 0, 1);
    add(1, 32'h500, 1, 1, 0, 0);
    e_c1 = 32'h100; e_c5 = 32'h500; e_sel = 15'h0;
    add(0, 32'd0, 0, 0, 0, 1);

    // ---------------- reset ----------------
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_data = '0; cfg_last = 1'b0;
    #1;
    chk_all_zero("rst");
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_ready", 32'(cfg_ready), 32'd1);

    // ---------------- table ----------------
    foreach (tbl[k]) begin
      step(tbl[k].v, tbl[k].d, tbl[k].l);
      chk($sformatf("v%0d_done", k), 32'(cfg_done), 32'(tbl[k].done));
      chk($sformatf("v%0d_err", k), 32'(cfg_err), 32'(tbl[k].err));
      chk($sformatf("v%0d_ready", k), 32'(cfg_ready), 32'(tbl[k].rdy));
      chk($sformatf("v%0d_loaded", k), 32'(cfg_loaded), 32'(tbl[k].ld));
      chk($sformatf("v%0d_c1", k), cons_1, tbl[k].c1);
      chk($sformatf("v%0d_c5", k), cons_5, tbl[k].c5);
      chk($sformatf("v%0d_sel", k), 32'(w_sel), 32'(tbl[k].sel));
    end
    chk("c_c2", cons_2, 32'h200);
    chk("c_c3", cons_3, 32'h300);
    chk("c_c4", cons_4, 32'h400);

    // ---------------- reset mid-load ----------------
    step(1, 32'hA70C_5555, 0);
    step(1, 32'h11, 0);
    step(1, 32'h22, 0);
    step(1, 32'h33, 0);
    cfg_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk); #3;
    rst_n = 1'b1;
    step(0, 32'd0, 0);
    chk("midrst_ready", 32'(cfg_ready), 32'd1);
    // Words that would finish the lost frame must be treated as a new (bad) header
    step(1, 32'h44, 0);
    chk("midrst_noresume_err", 32'(cfg_err), 32'd1);
    step(1, 32'h55, 1);
    step(1, 32'hA70C_2AAA, 0);
    step(1, 32'hCAFE_0001, 0);
    step(1, 32'hCAFE_0002, 0);
    step(1, 32'hCAFE_0003, 0);
    step(1, 32'hCAFE_0004, 0);
    step(1, 32'hCAFE_0005, 1);
    chk("midrst_done", 32'(cfg_done), 32'd1);
    step(0, 32'd0, 0);
    chk("midrst_c1", cons_1, 32'hCAFE_0001);
    chk("midrst_c3", cons_3, 32'hCAFE_0003);
    chk("midrst_c5", cons_5, 32'hCAFE_0005);
    chk("midrst_sel", 32'(w_sel), 32'h2AAA);
    chk("midrst_loaded", 32'(cfg_loaded), 32'd1);

    // ---------------- random gaps, 100 good frames ----------------
    for (int f = 0; f < 100; f++) begin
      frm[0] = {16'hA70C, 16'($urandom)};
      for (int w = 1; w < 6; w++) frm[w] = $urandom;
      for (int w = 0; w < 6; w++) begin
        gap = $urandom_range(0, 5);
        for (int g = 0; g < gap; g++) begin
          step(0, $urandom, 1'($urandom));
          chk($sformatf("r%0d_gap_ready", f), 32'(cfg_ready), 32'd1);
        end
        step(1, frm[w], (w == 5));
        chk($sformatf("r%0d_w%0d_ready", f, w), 32'(cfg_ready), (w == 5) ? 32'd0 : 32'd1);
        chk($sformatf("r%0d_w%0d_done", f, w), 32'(cfg_done), (w == 5) ? 32'd1 : 32'd0);
        chk($sformatf("r%0d_w%0d_err", f, w), 32'(cfg_err), 32'd0);
      end
      step(0, 32'd0, 0);
      chk($sformatf("r%0d_c1", f), cons_1, frm[1]);
      chk($sformatf("r%0d_c2", f), cons_2, frm[2]);
      chk($sformatf("r%0d_c3", f), cons_3, frm[3]);
      chk($sformatf("r%0d_c4", f), cons_4, frm[4]);
      chk($sformatf("r%0d_c5", f), cons_5, frm[5]);
      chk($sformatf("r%0d_sel", f), 32'(w_sel), 32'(frm[0][14:0]));
      chk($sformatf("r%0d_ready", f), 32'(cfg_ready), 32'd1);
      chk($sformatf("r%0d_done_low", f), 32'(cfg_done), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
